// File: rtl/fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// fifo_pkg : shared constants and keep-mask helper for the byte drain path
// Rev 1.0
// ---------------------------------------------------------------------
package fifo_pkg;

  localparam int BYTE_W            = 8;
  localparam int OUT_BYTES_DEFAULT = 4;

  function automatic logic [7:0] keep_mask(input logic [3:0] cnt);
    keep_mask = 8'((9'd1 << cnt) - 9'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_out_reg.sv
`default_nettype none
// ---------------------------------------------------------------------
// word_out_reg : valid/ready holding register for packed output words
// Rev 1.0
// ---------------------------------------------------------------------
module word_out_reg
  import fifo_pkg::*;
#(
  parameter int OUT_BYTES = OUT_BYTES_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic                        ready,
  input  logic [BYTE_W*OUT_BYTES-1:0] data_in,
  input  logic [OUT_BYTES-1:0]        keep_in,
  output logic                        out_valid,
  output logic [BYTE_W*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]        out_keep
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data_in;
      out_keep  <= keep_in;
    end else if (out_valid && ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------
// fifo_word_packer : pops bytes from the byte FIFO and packs them
// little-endian into keep-masked words on a valid/ready stream. Rev 1.0
// ---------------------------------------------------------------------
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int OUT_BYTES = OUT_BYTES_DEFAULT,
  parameter int CNT_BITS  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        empty,
  input  logic [BYTE_W-1:0]           rdata,
  output logic                        ren,
  input  logic                        flush,
  output logic [BYTE_W*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]        out_keep,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(OUT_BYTES);

  logic [BYTE_W*OUT_BYTES-1:0] asm_word;
  logic [BYTE_W*OUT_BYTES-1:0] word_data;
  logic [OUT_BYTES-1:0]        word_keep;
  logic [OUT_BYTES-1:0]        lane_we;
  logic [CNT_BITS-1:0]         cnt;
  logic                        flush_pending;
  logic                        free;
  logic                        full;
  logic                        xfer;

  assign free = !out_valid || out_ready;
  assign full = (cnt == FULL_CNT);
  assign xfer = free && (full || (flush_pending && cnt != '0));
  assign ren  = rst_n && !empty && !flush_pending && (!full || xfer);
  assign busy = (cnt != '0) || out_valid || flush_pending;

  assign word_keep = OUT_BYTES'(keep_mask(4'(cnt)));

  // A pop that coincides with a transfer starts the next word in lane 0.
  for (genvar i = 0; i < OUT_BYTES; i++) begin : g_lane
    assign lane_we[i] = ren && (xfer ? (i == 0) : (cnt == CNT_BITS'(i)));
    assign word_data[i*BYTE_W +: BYTE_W] =
      word_keep[i] ? asm_word[i*BYTE_W +: BYTE_W] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_word      <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
    end else begin
      for (int i = 0; i < OUT_BYTES; i++) begin
        if (lane_we[i]) asm_word[i*BYTE_W +: BYTE_W] <= rdata;
      end
      if (xfer)     cnt <= ren ? CNT_BITS'(1) : '0;
      else if (ren) cnt <= cnt + CNT_BITS'(1);
      // Re-arming is blocked while pending, otherwise a flush racing the
      // transfer could leave a pending flag with nothing to emit.
      if (flush && !flush_pending && (cnt != '0 || ren)) flush_pending <= 1'b1;
      else if (xfer)                                     flush_pending <= 1'b0;
    end
  end

  word_out_reg #(
    .OUT_BYTES (OUT_BYTES)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (xfer),
    .ready     (out_ready),
    .data_in   (word_data),
    .keep_in   (word_keep),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_fifo_word_packer : scoreboard bench with a behavioural byte FIFO
// Rev 1.0
// ---------------------------------------------------------------------
module tb_fifo_word_packer;

  localparam int OB = 4;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        empty = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        ren;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        busy;

  logic [7:0] fifo_q[$];
  logic [7:0] acc[$];
  exp_t       exp_q[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int words = 0;
  int pops = 0;
  int last_acc = -1;
  bit track_gap = 1'b0;

  always #5 clk = ~clk;

  fifo_word_packer #(.OUT_BYTES(OB), .CNT_BITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .empty     (empty),
    .rdata     (rdata),
    .ren       (ren),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural FIFO with asynchronous read.
  always @(posedge clk) begin
    cycle++;
    if (ren) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pops++;
    end
    empty <= (fifo_q.size() == 0);
    rdata <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ren) check_val("ren_vs_empty", empty, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_word", exp_q.size(), 1);
        end else begin
          check_val("data", out_data, exp_q[0].d);
          check_val("keep", out_keep, exp_q[0].k);
          if (out_ready) begin
            void'(exp_q.pop_front());
            words++;
            if (track_gap && last_acc >= 0) check_val("word_gap", cycle - last_acc, 4);
            last_acc = cycle;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] keep);
    exp_t e;
    e.d = '0;
    for (int i = 0; i < acc.size(); i++) e.d[i*8 +: 8] = acc[i];
    e.k = keep;
    exp_q.push_back(e);
    acc.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    acc.push_back(b);
    if (acc.size() == OB) push_exp(4'hF);
    empty = 1'b0;
    rdata = fifo_q[0];
  endtask

  task automatic pulse_flush();
    if (acc.size() > 0) push_exp(4'((5'd1 << acc.size()) - 5'd1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int start;
    int c;
    start = words;
    c = 0;
    while (words < start + n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_val(tag, words - start, n);
  endtask

  initial begin
    int w0;
    int p0;
    bit ren_seen;

    // Reset held while the FIFO already holds data.
    rst_n = 1'b0;
    out_ready = 1'b1;
    tick();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("ren_in_reset", ren, 0);
    end
    check_val("rst_valid", out_valid, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_keep", out_keep, 0);
    check_val("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_words("first_word", 1, 20);

    // Back-to-back stream, words must be exactly 4 cycles apart.
    tick();
    track_gap = 1'b1;
    last_acc = -1;
    for (int i = 1; i <= 12; i++) push_byte(8'(i));
    wait_words("stream_words", 3, 40);
    track_gap = 1'b0;

    // Partial word via flush, then a flush with nothing held.
    tick();
    push_byte(8'hAA); push_byte(8'hBB);
    repeat (4) tick();
    pulse_flush();
    wait_words("flush_word", 1, 10);
    repeat (2) tick();
    w0 = words;
    pulse_flush();
    repeat (6) tick();
    check_val("flush_empty_words", words, w0);
    check_val("flush_empty_busy", busy, 0);

    // Backpressure with 8 bytes available.
    out_ready = 1'b0;
    p0 = pops;
    push_byte(8'hC0); push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
    push_byte(8'hD0); push_byte(8'hD1); push_byte(8'hD2); push_byte(8'hD3);
    repeat (16) tick();
    check_val("bp_ren", ren, 0);
    check_val("bp_pops", pops - p0, 8);
    check_val("bp_valid", out_valid, 1);
    check_val("bp_busy", busy, 1);
    out_ready = 1'b1;
    wait_words("bp_words", 2, 20);
    tick();
    check_val("bp_pops_after", pops - p0, 8);

    // Idle with an empty FIFO.
    ren_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ren_seen |= ren;
    end
    check_val("idle_ren", ren_seen, 0);
    check_val("idle_busy", busy, 0);

    // Asynchronous reset mid-word and mid-handshake.
    out_ready = 1'b0;
    push_byte(8'hE0); push_byte(8'hE1); push_byte(8'hE2);
    push_byte(8'hE3); push_byte(8'hE4); push_byte(8'hE5);
    repeat (10) tick();
    check_val("pre_rst_valid", out_valid, 1);
    check_val("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_valid", out_valid, 0);
    check_val("async_data", out_data, 0);
    check_val("async_keep", out_keep, 0);
    check_val("async_ren", ren, 0);
    check_val("async_busy", busy, 0);
    fifo_q.delete();
    acc.delete();
    exp_q.delete();
    empty = 1'b1;
    rdata = 8'h00;
    tick();
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    push_byte(8'h5A); push_byte(8'h6B); push_byte(8'h7C); push_byte(8'h8D);
    wait_words("post_rst_word", 1, 20);
    repeat (3) tick();
    check_val("final_scoreboard", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
